// File: rtl/seq_det_param.sv
// Parametrised serial pattern detector: runtime-loadable pattern and length,
// overlapping or non-overlapping matching, one-cycle hit pulse and saturating hit counter.
module seq_det_param #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seq_vld,
  input  logic             seq_in,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pat_cfg,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             ovl_en,
  input  logic             clr_cnt,
  output logic             seq_out,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             cfg_err
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [PAT_W-1:0] hist_r, hist_s;
  logic [LEN_W-1:0] fill_r, fill_s;
  logic [PAT_W-1:0] pat_r, pat_s;
  logic [LEN_W-1:0] len_r, len_s;
  logic             ovl_r, ovl_s;
  logic             err_r, err_s;
  logic             out_r, out_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;

  logic             consume_s;
  logic             cfg_bad_s;
  logic [PAT_W-1:0] hist_sh_s;
  logic [LEN_W-1:0] fill_inc_s;
  logic [PAT_W-1:0] mask_s;
  logic             match_s;

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_r <= {PAT_W{1'b0}};
      fill_r <= {LEN_W{1'b0}};
      pat_r  <= {PAT_W{1'b0}};
      len_r  <= {LEN_W{1'b0}};
      ovl_r  <= 1'b0;
      err_r  <= 1'b1;
      out_r  <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
    end else begin
      hist_r <= hist_s;
      fill_r <= fill_s;
      pat_r  <= pat_s;
      len_r  <= len_s;
      ovl_r  <= ovl_s;
      err_r  <= err_s;
      out_r  <= out_s;
      cnt_r  <= cnt_s;
    end
  end

  // Match datapath: candidate history, saturating fill and length mask
  always_comb begin
    consume_s  = seq_vld & ~cfg_load & ~err_r;
    cfg_bad_s  = (pat_len == {LEN_W{1'b0}}) || (pat_len > FILL_MAX);
    hist_sh_s  = {hist_r[PAT_W-2:0], seq_in};
    fill_inc_s = (fill_r == FILL_MAX) ? fill_r : fill_r + {{(LEN_W-1){1'b0}}, 1'b1};
    mask_s     = {PAT_W{1'b0}};
    for (int i = 0; i < PAT_W; i++) begin
      mask_s[i] = (LEN_W'(i) < len_r);
    end
    // Only the newest len_r bits take part; higher pattern bits are don't-care
    match_s = consume_s && (fill_inc_s >= len_r) &&
              (((hist_sh_s ^ pat_r) & mask_s) == {PAT_W{1'b0}});
  end

  // Next-state logic: cfg_load outranks a simultaneous consume
  always_comb begin
    hist_s = hist_r;
    fill_s = fill_r;
    pat_s  = pat_r;
    len_s  = len_r;
    ovl_s  = ovl_r;
    err_s  = err_r;
    out_s  = match_s;
    if (cfg_load) begin
      pat_s  = pat_cfg;
      len_s  = pat_len;
      ovl_s  = ovl_en;
      err_s  = cfg_bad_s;
      hist_s = {PAT_W{1'b0}};
      fill_s = {LEN_W{1'b0}};
    end else if (consume_s) begin
      hist_s = hist_sh_s;
      fill_s = (match_s && !ovl_r) ? {LEN_W{1'b0}} : fill_inc_s;
    end else begin
      hist_s = hist_r;
      fill_s = fill_r;
    end
    // Clear wins over a same-cycle hit; the pulse itself is unaffected
    if (clr_cnt) begin
      cnt_s = {CNT_W{1'b0}};
    end else if (match_s && (cnt_r != CNT_MAX)) begin
      cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Outputs driven straight from registers
  always_comb begin
    seq_out = out_r;
    hit_cnt = cnt_r;
    cfg_err = err_r;
  end

endmodule

// File: tb/tb_seq_det_param.sv
// Scoreboard bench for seq_det_param: directed scenarios then randomized traffic,
// checked against a bit-queue reference model.
module tb_seq_det_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       seq_vld = 1'b0;
  logic       seq_in = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] pat_cfg = 8'h00;
  logic [3:0] pat_len = 4'd0;
  logic       ovl_en = 1'b0;
  logic       clr_cnt = 1'b0;
  logic        out_a, err_a, out_b, err_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  always #5 clk = ~clk;

  seq_det_param #(.PAT_W(8), .LEN_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .seq_vld(seq_vld), .seq_in(seq_in), .cfg_load(cfg_load),
    .pat_cfg(pat_cfg), .pat_len(pat_len), .ovl_en(ovl_en), .clr_cnt(clr_cnt),
    .seq_out(out_a), .hit_cnt(cnt_a), .cfg_err(err_a));

  seq_det_param #(.PAT_W(8), .LEN_W(4), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .seq_vld(seq_vld), .seq_in(seq_in), .cfg_load(cfg_load),
    .pat_cfg(pat_cfg), .pat_len(pat_len), .ovl_en(ovl_en), .clr_cnt(clr_cnt),
    .seq_out(out_b), .hit_cnt(cnt_b), .cfg_err(err_b));

  typedef struct packed {
    logic        out;
    logic [15:0] c16;
    logic [1:0]  c2;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  // reference model state
  bit       m_bits[$];
  bit [7:0] m_pat;
  int       m_len;
  bit       m_ovl;
  bit       m_err;
  int       m_c16;
  int       m_c2;

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, want);
    end
  endtask

  // monitor: one expected record per clock edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("seq_out",     int'(out_a), int'(e.out));
      check("seq_out_c2",  int'(out_b), int'(e.out));
      check("hit_cnt",     int'(cnt_a), int'(e.c16));
      check("hit_cnt_c2",  int'(cnt_b), int'(e.c2));
      check("cfg_err",     int'(err_a), int'(e.err));
      check("cfg_err_c2",  int'(err_b), int'(e.err));
    end
  end

  task automatic step(input bit r, input bit ld, input logic [7:0] pc, input logic [3:0] pl,
                      input bit ov, input bit v, input bit b, input bit clr);
    bit   hit;
    exp_t e;
    @(negedge clk);
    rst = r; cfg_load = ld; pat_cfg = pc; pat_len = pl; ovl_en = ov;
    seq_vld = v; seq_in = b; clr_cnt = clr;
    hit = 1'b0;
    if (r) begin
      m_bits.delete();
      m_pat = 8'h00; m_len = 0; m_ovl = 1'b0; m_err = 1'b1;
      m_c16 = 0; m_c2 = 0;
    end else begin
      if (ld) begin
        m_pat = pc; m_len = int'(pl); m_ovl = ov;
        m_err = (pl == 4'd0) || (pl > 4'd8);
        m_bits.delete();
      end else if (v && !m_err) begin
        m_bits.push_back(b);
        if (m_bits.size() > 8) void'(m_bits.pop_front());
        if (m_bits.size() >= m_len) begin
          hit = 1'b1;
          for (int i = 0; i < m_len; i++)
            if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) hit = 1'b0;
        end
        if (hit && !m_ovl) m_bits.delete();
      end
      if (clr) begin
        m_c16 = 0; m_c2 = 0;
      end else if (hit) begin
        if (m_c16 < 65535) m_c16++;
        if (m_c2 < 3) m_c2++;
      end
    end
    e.out = hit; e.c16 = 16'(m_c16); e.c2 = 2'(m_c2); e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic do_rst();
    step(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [7:0] pc, input logic [3:0] pl, input bit ov);
    step(1'b0, 1'b1, pc, pl, ov, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic bitv(input bit v, input bit b, input bit clr);
    step(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, v, b, clr);
  endtask

  task automatic send(input logic [31:0] s, input int n);
    logic [31:0] t;
    t = s;
    for (int i = n - 1; i >= 0; i--) bitv(1'b1, t[i], 1'b0);
  endtask

  initial begin
    // 1: overlapping 1101
    do_rst();
    load(8'b0000_1101, 4'd4, 1'b1);
    send(32'b1101101, 7);
    // 2: non-overlapping
    do_rst();
    load(8'b0000_1101, 4'd4, 1'b0);
    send(32'b1101101, 7);
    // 3: gaps keep a partial match; reload mid-pattern discards it
    do_rst();
    load(8'b0000_1101, 4'd4, 1'b1);
    send(32'b11, 2);
    repeat (3) bitv(1'b0, 1'b1, 1'b0);
    send(32'b01, 2);
    send(32'b110, 3);
    load(8'b0000_1101, 4'd4, 1'b1);
    send(32'b1, 1);
    // 4: invalid lengths, then full-width pattern
    load(8'hA5, 4'd0, 1'b1);
    send(32'hA5A5, 16);
    load(8'hA5, 4'd9, 1'b1);
    send(32'hA5A5, 16);
    load(8'hA5, 4'd8, 1'b0);
    send(32'b10100101, 8);
    // 5: single-bit pattern, saturation, clear on a hit
    do_rst();
    load(8'h01, 4'd1, 1'b0);
    send(32'b11111, 5);
    bitv(1'b1, 1'b1, 1'b1);
    bitv(1'b1, 1'b0, 1'b0);
    // 6: reset mid-stream
    load(8'b0000_1101, 4'd4, 1'b1);
    send(32'b110, 3);
    do_rst();
    send(32'b1, 1);
    // randomized traffic
    load(8'h0D, 4'd4, 1'b1);
    for (int k = 0; k < 3000; k++) begin
      bit         r, ld, ov, v, b, clr;
      logic [3:0] pl;
      logic [7:0] pc;
      r   = ($urandom_range(0, 499) == 0);
      ld  = ($urandom_range(0, 39) == 0);
      pl  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      pc  = 8'($urandom);
      ov  = 1'($urandom);
      v   = ($urandom_range(0, 3) != 0);
      b   = 1'($urandom);
      clr = ($urandom_range(0, 49) == 0);
      step(r, ld, pc, pl, ov, v, b, clr);
    end
    bitv(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
